// File: rtl/qr_solve.sv
// Back-substitution solver for R*x = Q^T*y using one shared MAC and a restoring divider.
// Optional QR_SOLVE_SAT_EN: saturate results to WIDTH bits instead of wrapping.
module qr_solve #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] q11, q12, q13, q14,
    input  logic signed [WIDTH-1:0] q21, q22, q23, q24,
    input  logic signed [WIDTH-1:0] q31, q32, q33, q34,
    input  logic signed [WIDTH-1:0] q41, q42, q43, q44,
    input  logic signed [WIDTH-1:0] r11, r12, r13, r14,
    input  logic signed [WIDTH-1:0] r22, r23, r24,
    input  logic signed [WIDTH-1:0] r33, r34,
    input  logic signed [WIDTH-1:0] r44,
    input  logic signed [WIDTH-1:0] y1, y2, y3, y4,
    output logic signed [WIDTH-1:0] x1, x2, x3, x4,
    output logic                    finish,
    output logic                    div0
);

    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = 2 * WIDTH + 3;
    localparam int QB   = 2 * WIDTH + 2;
    localparam int DVW  = WIDTH + 1;
    localparam int CW   = $clog2(QB);

    localparam logic signed [WIDTH-1:0] XMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] XMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, QTY, SETUP, MAC, DIV, WB, DONE} state_t;

    state_t                  state;
    logic                    start_d;
    logic signed [WIDTH-1:0] q_m [4][4];
    logic signed [WIDTH-1:0] r_m [4][4];
    logic signed [WIDTH-1:0] y_m [4];
    logic signed [WIDTH-1:0] z_m [4];
    logic signed [WIDTH-1:0] x_m [4];
    logic signed [ACCW-1:0]  acc;
    logic [3:0]              k;
    logic [1:0]              row;
    logic [1:0]              col;
    logic [CW-1:0]           div_cnt;
    logic [QB-1:0]           dvd;
    logic [DVW-1:0]          rem;

    function automatic logic signed [WIDTH-1:0] fmt(input logic signed [ACCW-1:0] v);
`ifdef QR_SOLVE_SAT_EN
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = ACCW'((2 ** (WIDTH - 1)) - 1);
        lo = ~hi;
        if (v > hi)
            return XMAX;
        else if (v < lo)
            return XMIN;
        else
            return WIDTH'(v);
`else
        return WIDTH'(v);
`endif
    endfunction

    logic                    launch;
    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  qty_sum;
    logic signed [ACCW-1:0]  z_shift;
    logic signed [WIDTH-1:0] rii;
    logic signed [DVW-1:0]   rii_ext;
    logic [DVW-1:0]          divisor;
    logic [QB-1:0]           acc_mag;
    logic [QB-1:0]           dvd_in;
    logic [DVW-1:0]          rem_in;
    logic [DVW:0]            shifted;
    logic [DVW:0]            trial;
    logic                    qbit;
    logic signed [ACCW-1:0]  q_ext;
    logic signed [ACCW-1:0]  q_res;
    logic signed [WIDTH-1:0] wb_val;

    assign launch = ((state == IDLE) || (state == DONE)) && start && !start_d;

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (state)
            QTY: begin
                mac_a = q_m[k[1:0]][k[3:2]];
                mac_b = y_m[k[1:0]];
            end
            MAC: begin
                mac_a = r_m[row][col];
                mac_b = x_m[col];
            end
            default: ;
        endcase
    end

    assign prod     = mac_a * mac_b;
    assign prod_ext = ACCW'(prod);
    assign qty_sum  = acc + prod_ext;
    assign z_shift  = qty_sum >>> FBITS;

    assign rii     = r_m[row][row];
    assign rii_ext = {rii[WIDTH-1], rii};
    assign divisor = rii_ext[DVW-1] ? DVW'(-rii_ext) : DVW'(rii_ext);

    // |acc| stays below 2^(2*WIDTH+1), so the low QB bits hold the full magnitude.
    assign acc_mag = acc[ACCW-1] ? QB'(-acc) : acc[QB-1:0];
    assign dvd_in  = (div_cnt == '0) ? acc_mag : dvd;
    assign rem_in  = (div_cnt == '0) ? '0 : rem;
    assign shifted = {rem_in, dvd_in[QB-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign qbit    = ~trial[DVW];

    assign q_ext = {1'b0, dvd};
    assign q_res = (acc[ACCW-1] ^ rii[WIDTH-1]) ? -q_ext : q_ext;

    always_comb begin
        wb_val = fmt(q_res);
        if (rii == '0) begin
            if (acc == '0)
                wb_val = '0;
            else if (acc[ACCW-1])
                wb_val = XMIN;
            else
                wb_val = XMAX;
        end
    end

    // Sequencer: capture on launch, then Q^T*y, then rows 4..1 of back-substitution.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_d <= 1'b0;
            finish  <= 1'b0;
            div0    <= 1'b0;
            acc     <= '0;
            k       <= '0;
            row     <= '0;
            col     <= '0;
            div_cnt <= '0;
            dvd     <= '0;
            rem     <= '0;
            for (int a = 0; a < 4; a++) begin
                y_m[a] <= '0;
                z_m[a] <= '0;
                x_m[a] <= '0;
                for (int b = 0; b < 4; b++) begin
                    q_m[a][b] <= '0;
                    r_m[a][b] <= '0;
                end
            end
        end else begin
            start_d <= start;
            if (launch) begin
                q_m[0][0] <= q11; q_m[0][1] <= q12; q_m[0][2] <= q13; q_m[0][3] <= q14;
                q_m[1][0] <= q21; q_m[1][1] <= q22; q_m[1][2] <= q23; q_m[1][3] <= q24;
                q_m[2][0] <= q31; q_m[2][1] <= q32; q_m[2][2] <= q33; q_m[2][3] <= q34;
                q_m[3][0] <= q41; q_m[3][1] <= q42; q_m[3][2] <= q43; q_m[3][3] <= q44;
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++)
                        r_m[a][b] <= '0;
                r_m[0][0] <= r11; r_m[0][1] <= r12; r_m[0][2] <= r13; r_m[0][3] <= r14;
                r_m[1][1] <= r22; r_m[1][2] <= r23; r_m[1][3] <= r24;
                r_m[2][2] <= r33; r_m[2][3] <= r34;
                r_m[3][3] <= r44;
                y_m[0] <= y1; y_m[1] <= y2; y_m[2] <= y3; y_m[3] <= y4;
                state  <= QTY;
                k      <= '0;
                acc    <= '0;
                finish <= 1'b0;
                div0   <= 1'b0;
            end else begin
                case (state)
                    QTY: begin
                        k <= k + 4'd1;
                        if (k[1:0] == 2'd3) begin
                            z_m[k[3:2]] <= fmt(z_shift);
                            acc <= '0;
                        end else begin
                            acc <= qty_sum;
                        end
                        if (k == 4'd15) begin
                            state <= SETUP;
                            row   <= 2'd3;
                        end
                    end
                    SETUP: begin
                        acc     <= ACCW'(z_m[row]) <<< FBITS;
                        div_cnt <= '0;
                        if (row == 2'd3) begin
                            state <= DIV;
                        end else begin
                            col   <= row + 2'd1;
                            state <= MAC;
                        end
                    end
                    MAC: begin
                        acc <= acc - prod_ext;
                        if (col == 2'd3)
                            state <= DIV;
                        else
                            col <= col + 2'd1;
                    end
                    DIV: begin
                        dvd <= {dvd_in[QB-2:0], qbit};
                        rem <= qbit ? trial[DVW-1:0] : shifted[DVW-1:0];
                        if (div_cnt == CW'(QB - 1))
                            state <= WB;
                        else
                            div_cnt <= div_cnt + CW'(1);
                    end
                    WB: begin
                        x_m[row] <= wb_val;
                        if (rii == '0)
                            div0 <= 1'b1;
                        if (row == 2'd0) begin
                            state <= DONE;
                        end else begin
                            row   <= row - 2'd1;
                            state <= SETUP;
                        end
                    end
                    DONE: finish <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign x1 = x_m[0];
    assign x2 = x_m[1];
    assign x3 = x_m[2];
    assign x4 = x_m[3];

endmodule

// File: tb/tb_qr_solve.sv
// Directed self-checking bench for qr_solve: hand-computed solutions, latency, div0 and reset behaviour.
module tb_qr_solve;

    localparam int W = 16;
    localparam int EXP_LAT = 8 * W + 39;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic signed [W-1:0] qm [4][4];
    logic signed [W-1:0] rm [4][4];
    logic signed [W-1:0] ym [4];
    logic signed [W-1:0] x1, x2, x3, x4;
    logic finish, div0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qr_solve #(.WIDTH(W), .FBITS(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .q11(qm[0][0]), .q12(qm[0][1]), .q13(qm[0][2]), .q14(qm[0][3]),
        .q21(qm[1][0]), .q22(qm[1][1]), .q23(qm[1][2]), .q24(qm[1][3]),
        .q31(qm[2][0]), .q32(qm[2][1]), .q33(qm[2][2]), .q34(qm[2][3]),
        .q41(qm[3][0]), .q42(qm[3][1]), .q43(qm[3][2]), .q44(qm[3][3]),
        .r11(rm[0][0]), .r12(rm[0][1]), .r13(rm[0][2]), .r14(rm[0][3]),
        .r22(rm[1][1]), .r23(rm[1][2]), .r24(rm[1][3]),
        .r33(rm[2][2]), .r34(rm[2][3]),
        .r44(rm[3][3]),
        .y1(ym[0]), .y2(ym[1]), .y3(ym[2]), .y4(ym[3]),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .finish(finish), .div0(div0)
    );

    task automatic load_identity(input logic [W-1:0] rdiag);
        for (int a = 0; a < 4; a++) begin
            ym[a] = '0;
            for (int b = 0; b < 4; b++) begin
                qm[a][b] = (a == b) ? 16'h0100 : 16'h0000;
                rm[a][b] = (a == b) ? rdiag : 16'h0000;
            end
        end
    endtask

    task automatic run_solve(input bit scramble, output int lat, output logic fin0, output logic d00);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        fin0 = finish;
        d00 = div0;
        if (scramble) begin
            for (int a = 0; a < 4; a++) begin
                ym[a] = W'($urandom);
                for (int b = 0; b < 4; b++) begin
                    qm[a][b] = W'($urandom);
                    rm[a][b] = W'($urandom);
                end
            end
        end
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        load_identity(16'h0100);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({x1, x2, x3, x4, finish, div0} !== 66'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got x=%h %h %h %h fin=%b d0=%b required all 0", x1, x2, x3, x4, finish, div0);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int lat;
        logic f0, d0;
        load_identity(16'h0100);
        ym[0] = 16'h0100; ym[1] = 16'h0200; ym[2] = 16'h0300; ym[3] = 16'h0400;
        run_solve(1'b1, lat, f0, d0);
        n_checks++;
        if (lat != EXP_LAT) begin
            n_fail++;
            $display("[TB] FAIL identity_latency: got %0d required %0d", lat, EXP_LAT);
        end
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0100_0200_0300_0400) begin
            n_fail++;
            $display("[TB] FAIL identity_x: got %h %h %h %h required 0100 0200 0300 0400", x1, x2, x3, x4);
        end
        n_checks++;
        if (div0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL identity_div0: got %b required 0", div0);
        end
    endtask

    task automatic test_scaled();
        int lat;
        logic f0, d0;
        load_identity(16'h0200);
        for (int a = 0; a < 4; a++) ym[a] = 16'h0100;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if (f0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL launch_clears_finish: got %b required 0", f0);
        end
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0080_0080_0080_0080 || lat != EXP_LAT) begin
            n_fail++;
            $display("[TB] FAIL scaled_x: got %h %h %h %h lat %0d required 0080 x4 lat %0d", x1, x2, x3, x4, lat, EXP_LAT);
        end
    endtask

    task automatic test_bidiagonal();
        int lat;
        logic f0, d0;
        load_identity(16'h0100);
        rm[0][1] = 16'h0100; rm[1][2] = 16'h0100; rm[2][3] = 16'h0100;
        ym[0] = 16'h0400; ym[1] = 16'h0300; ym[2] = 16'h0200; ym[3] = 16'h0100;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0200_0200_0100_0100) begin
            n_fail++;
            $display("[TB] FAIL bidiag_x: got %h %h %h %h required 0200 0200 0100 0100", x1, x2, x3, x4);
        end
    endtask

    task automatic test_signed_trunc();
        int lat;
        logic f0, d0;
        load_identity(16'h0100);
        rm[2][2] = 16'hFD00; rm[3][3] = 16'h0300;
        ym[0] = 16'hFF80; ym[1] = 16'h0100; ym[2] = 16'h0100; ym[3] = 16'hFF00;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'hFF80_0100_FFAB_FFAB) begin
            n_fail++;
            $display("[TB] FAIL signed_trunc_x: got %h %h %h %h required FF80 0100 FFAB FFAB", x1, x2, x3, x4);
        end
    endtask

    task automatic test_permutation();
        int lat;
        logic f0, d0;
        load_identity(16'h0100);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                qm[a][b] = 16'h0000;
        qm[0][1] = 16'h0100; qm[1][2] = 16'h0100; qm[2][3] = 16'h0100; qm[3][0] = 16'h0100;
        ym[0] = 16'h0100; ym[1] = 16'h0200; ym[2] = 16'h0300; ym[3] = 16'h0400;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0400_0100_0200_0300) begin
            n_fail++;
            $display("[TB] FAIL permutation_x: got %h %h %h %h required 0400 0100 0200 0300", x1, x2, x3, x4);
        end
    endtask

    task automatic test_div0();
        int lat;
        logic f0, d0;
        load_identity(16'h0100);
        rm[1][1] = 16'h0000;
        ym[0] = 16'h0100; ym[1] = 16'h0200; ym[2] = 16'h0300; ym[3] = 16'h0400;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0100_7FFF_0300_0400 || div0 !== 1'b1 || lat != EXP_LAT) begin
            n_fail++;
            $display("[TB] FAIL div0_pos: got %h %h %h %h d0=%b lat %0d required 0100 7FFF 0300 0400 d0=1 lat %0d",
                     x1, x2, x3, x4, div0, lat, EXP_LAT);
        end
        rm[0][1] = 16'h0010;
        ym[1] = 16'hFF00;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if (d0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL launch_clears_div0: got %b required 0", d0);
        end
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0900_8000_0300_0400 || div0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL div0_neg: got %h %h %h %h d0=%b required 0900 8000 0300 0400 d0=1", x1, x2, x3, x4, div0);
        end
        ym[1] = 16'h0000;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0100_0000_0300_0400 || div0 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL div0_zero: got %h %h %h %h d0=%b required 0100 0000 0300 0400 d0=1", x1, x2, x3, x4, div0);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic f0, d0;
        logic [W-1:0] exp_x1;
`ifdef QR_SOLVE_SAT_EN
        exp_x1 = 16'h7FFF;
`else
        exp_x1 = 16'h0000;
`endif
        load_identity(16'h0100);
        rm[0][0] = 16'h0001;
        ym[0] = 16'h0100;
        run_solve(1'b0, lat, f0, d0);
        n_checks++;
        if (x1 !== exp_x1 || div0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_x1: got %h d0=%b required %h d0=0", x1, div0, exp_x1);
        end
    endtask

    task automatic test_reset_relaunch();
        int lat;
        load_identity(16'h0100);
        ym[0] = 16'h0100; ym[1] = 16'h0200; ym[2] = 16'h0300; ym[3] = 16'h0400;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({x1, x2, x3, x4, finish, div0} !== 66'd0) begin
            n_fail++;
            $display("[TB] FAIL midsolve_reset: got x=%h %h %h %h fin=%b d0=%b required all 0", x1, x2, x3, x4, finish, div0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (n == 40) start = 1'b0;
            if (n == 45) start = 1'b1;
            if (finish === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat != EXP_LAT) begin
            n_fail++;
            $display("[TB] FAIL relaunch_latency: got %0d required %0d", lat, EXP_LAT);
        end
        n_checks++;
        if ({x1, x2, x3, x4} !== 64'h0100_0200_0300_0400) begin
            n_fail++;
            $display("[TB] FAIL relaunch_x: got %h %h %h %h required 0100 0200 0300 0400", x1, x2, x3, x4);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scaled();
        test_bidiagonal();
        test_signed_trunc();
        test_permutation();
        test_div0();
        test_overflow();
        test_reset_relaunch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qr_solve.md
# qr_solve

Back-substitution stage that consumes the Q and R factors from the 4x4 QR decomposition block and solves H·x = y as R·x = Qᵀ·y. It sits directly downstream of that block. Its `start` is wired to the QR block's `finish` level, and its Q/R inputs come straight from the QR outputs. A single shared MAC and a sequential restoring divider produce x1..x4 in signed fixed point with a fixed, data-independent latency.

## Interface
- `WIDTH`, 16, word width (signed two's complement)
- `FBITS`, 8, fractional bits (Q(WIDTH-FBITS).FBITS)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: level; a rising edge launches a solve
- `q11..q44` in WIDTH each: Q matrix, 16 ports, qij = row i, column j
- `r11,r12,r13,r14,r22,r23,r24,r33,r34,r44` in WIDTH each: upper-triangular R
- `y1..y4` in WIDTH each: received vector
- `x1..x4` out WIDTH each: solution
- `finish` out 1: result valid; level
- `div0` out 1: some rii was zero in the last solve; sticky until next launch

## Operation
- **Launch**
  - Launch occurs when the state is IDLE or DONE, `start`=1, and the registered `start_d`=0.
  - On launch, all q, r and y inputs are captured into internal registers, so inputs may change afterwards.
  - Launch also clears `finish` and `div0`.
  - A `start` rising edge in any other state is ignored.
- **States:** IDLE → QTY → (SETUP → MAC → DIV → WB) ×4 rows, i = 4 down to 1 → DONE.
- **QTY** (16 cycles, k = 0..15, i = k/4+1, j = k%4+1)
  - acc += q_ji·y_j.
  - When j = 4: z_i = fmt(acc >> FBITS), then acc is cleared.
- **SETUP** (1 cycle): acc = z_i << FBITS.
- **MAC** (4−i cycles; 0 cycles for i = 4): for j = i+1..4, acc −= r_ij·x_j.
- **DIV** (2·WIDTH+2 cycles)
  - Restoring division of |acc| by |r_ii|, one quotient bit per cycle.
  - The sign is applied afterwards, giving truncation toward zero.
- **WB** (1 cycle): x_i = fmt(quotient).
- **Division by zero:** if r_ii = 0, the DIV cycles are still spent. x_i is then:
  - +max (0x7FFF) if acc > 0
  - −max (0x8000) if acc < 0
  - 0 if acc = 0
  - In all three cases `div0` is set.
- **Arithmetic**
  - Products are full 2·WIDTH signed.
  - acc is 2·WIDTH+3 bits signed.
  - Right shifts are arithmetic (floor).
- **fmt()**: reduction to WIDTH bits; see Configuration.
- **DONE**
  - `finish` = 1 and x1..x4 are held until the next launch or reset.
  - A new launch from DONE is legal. The upstream `finish` level must drop and rise again for a relaunch.
- **Reset** (any time, including mid-solve)
  - State returns to IDLE.
  - x1..x4, `finish`, `div0`, acc, z, `start_d` and all captured registers are cleared to 0.
  - If `start` is high when reset releases, `start_d` = 0 means it launches on the first edge.

## Timing
- Edge 0 is the launch edge. QTY occupies edges 1..16.
- Row i takes 2·WIDTH + 4 + (4−i) cycles. All four rows together take 8·WIDTH + 22 cycles.
- `finish` rises at edge 8·WIDTH + 39 after launch (167 for WIDTH = 16).
- Latency is constant regardless of data or `div0`.
- x_i updates at its own WB edge, in the order x4, x3, x2, x1. x values are only valid once `finish` = 1.
- Reset values of all outputs are 0.

## Configuration
- Macro: `QR_SOLVE_SAT_EN`.
- **Defined:** fmt() saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Undefined:** fmt() keeps the low WIDTH bits (wrap), matching the QR block's bit-slice behaviour.
- The `div0` forced ±max values are independent of the macro.

## Test plan
- **Identity:** Q = I, R = I (diag 0x0100), y = (0x0100, 0x0200, 0x0300, 0x0400) → x = y, `finish` at edge 167, `div0` = 0.
- **Scaled diagonal:** Q = I, R = 2·I (diag 0x0200), y = all 0x0100 → x = all 0x0080.
- **Bidiagonal back-substitution:**
  - Q = I; R has diag 0x0100 and r12 = r23 = r34 = 0x0100, all other off-diagonals 0.
  - y = (0x0400, 0x0300, 0x0200, 0x0100).
  - Required: x4 = 0x0100, x3 = 0x0100, x2 = 0x0200, x1 = 0x0200.
- **Division by zero:** the Identity case with r22 = 0 → `div0` = 1, x2 = 0x7FFF, `finish` still at edge 167. The x1 result must match a reference model fed the saturated x2.
- **Overflow:** Q = I, r11 = 0x0001, other diag 0x0100, y1 = 0x0100 → x1 = 0x7FFF with `QR_SOLVE_SAT_EN`, x1 = 0x0000 without.
- **Reset and relaunch:**
  - Assert reset at edge 60 → all outputs 0, state IDLE.
  - Hold `start` high through release → launch on the first edge, and `finish` 167 edges later.
  - A second rising edge on `start` while busy is ignored.
